// File: rtl/gf12_sram64_be_port_sched_pkg.sv
// rtl/gf12_sram64_be_port_sched_pkg.sv - shared types, defaults and bank decode for the SRAM port scheduler
package gf12_sram_ctrl_pkg;

  typedef enum logic {PRIO_WR = 1'b0, PRIO_RD = 1'b1} prio_e;

  localparam int DEF_ABITS      = 18;
  localparam int DEF_BANK_ABITS = 13;
  localparam int DEF_DBITS      = 64;
  localparam int DEF_RSP_DEPTH  = 2;
  localparam int DEF_CNT_BITS   = 16;

  // Takes a zero-extended address so callers of any ABITS up to 32 share one decoder.
  function automatic logic [31:0] bank_sel(input logic [31:0] addr, input int unsigned bank_abits);
    return addr >> bank_abits;
  endfunction

endpackage

// File: rtl/gf12_sram64_be_port_sched_if.sv
// rtl/gf12_sram64_be_port_sched_if.sv - request, response and SRAM port bundle of the scheduler
interface gf12_sram64_be_port_sched_if
  import gf12_sram_ctrl_pkg::*;
#(
  parameter int ABITS    = DEF_ABITS,
  parameter int DBITS    = DEF_DBITS,
  parameter int CNT_BITS = DEF_CNT_BITS
);
  logic                wr_valid;
  logic                wr_ready;
  logic [ABITS-1:0]    wr_addr;
  logic [DBITS-1:0]    wr_data;
  logic [DBITS-1:0]    wr_mask;
  logic                rd_valid;
  logic                rd_ready;
  logic [ABITS-1:0]    rd_addr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DBITS-1:0]    rsp_data;
  logic                sram_CE0;
  logic [ABITS-1:0]    sram_A0;
  logic [DBITS-1:0]    sram_D0;
  logic                sram_WE0;
  logic [DBITS-1:0]    sram_WEM0;
  logic                sram_CE1;
  logic [ABITS-1:0]    sram_A1;
  logic [DBITS-1:0]    sram_Q1;
  logic [CNT_BITS-1:0] conflict_cnt;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, sram_Q1,
    output wr_ready, rd_ready, rsp_valid, rsp_data,
    output sram_CE0, sram_A0, sram_D0, sram_WE0, sram_WEM0, sram_CE1, sram_A1, conflict_cnt
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, sram_Q1,
    input  wr_ready, rd_ready, rsp_valid, rsp_data,
    input  sram_CE0, sram_A0, sram_D0, sram_WE0, sram_WEM0, sram_CE1, sram_A1, conflict_cnt
  );

endinterface

// File: rtl/gf12_sram64_be_port_sched_rsp_fifo.sv
// rtl/gf12_sram64_be_port_sched_rsp_fifo.sv - read-response buffer; head is a register, Q1 is never bypassed
module gf12_sram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int DBITS = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DBITS-1:0] data_i,
  input  logic             pop_i,
  output logic [DBITS-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    // Push into a full buffer is only legal when the head leaves in the same cycle.
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/gf12_sram64_be_port_sched.sv
// rtl/gf12_sram64_be_port_sched.sv - write/read port arbiter with bank-conflict round robin and read credits
module gf12_sram64_be_port_sched
  import gf12_sram_ctrl_pkg::*;
#(
  parameter int ABITS      = DEF_ABITS,
  parameter int BANK_ABITS = DEF_BANK_ABITS,
  parameter int DBITS      = DEF_DBITS,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                         CLK,
  input  logic                         RST,
  gf12_sram64_be_port_sched_if.slave   bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  prio_e               prio_q, prio_d;
  logic                inflight_q, inflight_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic [CW-1:0]       occ;
  logic                fifo_empty, fifo_full;
  logic [DBITS-1:0]    fifo_head;
  logic [CW:0]         pending;
  logic                pop, rd_credit, same_bank;
  logic                wr_req, rd_ok, conflict, wr_gnt, rd_gnt;

  assign pop     = ~fifo_empty & bus.rsp_ready;
  assign pending = {1'b0, occ} + (CW+1)'(inflight_q);
  // A read already in the SRAM owns a buffer slot, so it counts against the credit.
  assign rd_credit = (pending < (CW+1)'(RSP_DEPTH)) |
                     ((pending == (CW+1)'(RSP_DEPTH)) & pop & (fifo_full | inflight_q));
  assign same_bank = (bank_sel(32'(bus.wr_addr), BANK_ABITS) ==
                      bank_sel(32'(bus.rd_addr), BANK_ABITS));

  always_comb begin
    wr_req     = bus.wr_valid & ~RST;
    rd_ok      = bus.rd_valid & rd_credit & ~RST;
    conflict   = wr_req & rd_ok & same_bank;
    wr_gnt     = wr_req & (~conflict | (prio_q == PRIO_WR));
    rd_gnt     = rd_ok  & (~conflict | (prio_q == PRIO_RD));
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    inflight_d = rd_gnt;
    if (conflict) begin
      prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q     <= PRIO_WR;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  gf12_sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .DBITS (DBITS),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (inflight_q),
    .data_i  (bus.sram_Q1),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  assign bus.wr_ready     = wr_gnt;
  assign bus.rd_ready     = rd_gnt;
  assign bus.rsp_valid    = ~fifo_empty;
  assign bus.rsp_data     = fifo_head;
  assign bus.conflict_cnt = cnt_q;

  // Idle ports drive zeros so waveforms only show live addresses and data.
  assign bus.sram_CE0  = wr_gnt;
  assign bus.sram_WE0  = wr_gnt;
  assign bus.sram_A0   = wr_gnt ? bus.wr_addr : '0;
  assign bus.sram_D0   = wr_gnt ? bus.wr_data : '0;
  assign bus.sram_WEM0 = wr_gnt ? bus.wr_mask : '0;
  assign bus.sram_CE1  = rd_gnt;
  assign bus.sram_A1   = rd_gnt ? bus.rd_addr : '0;

endmodule

// File: tb/tb_gf12_sram64_be_port_sched.sv
// tb/tb_gf12_sram64_be_port_sched.sv - directed bench with a behavioural SRAM behind the scheduler
module tb_gf12_sram64_be_port_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  gf12_sram64_be_port_sched_if #(.ABITS(18), .DBITS(64), .CNT_BITS(16)) bus ();

  gf12_sram64_be_port_sched #(
    .ABITS(18), .BANK_ABITS(13), .DBITS(64), .RSP_DEPTH(2), .CNT_BITS(16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM: Q1 registered one cycle after CE1, bit-masked write on port 0.
  logic [63:0] mem [logic [17:0]];
  logic [63:0] old_word;
  always @(posedge clk) begin
    if (bus.sram_CE1) bus.sram_Q1 <= mem.exists(bus.sram_A1) ? mem[bus.sram_A1] : 64'h0;
    if (bus.sram_CE0 && bus.sram_WE0) begin
      old_word = mem.exists(bus.sram_A0) ? mem[bus.sram_A0] : 64'h0;
      mem[bus.sram_A0] = (old_word & ~bus.sram_WEM0) | (bus.sram_D0 & bus.sram_WEM0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [63:0] exp);
    int n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk(tag, bus.rsp_data, exp);
    @(negedge clk); #1;
  endtask

  int          acc;
  int          acc_fast;
  logic [63:0] got [$];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 18'h00010;
    bus.wr_data   = 64'hDEAD;
    bus.wr_mask   = '1;
    bus.rd_valid  = 1'b1;
    bus.rd_addr   = 18'h02010;
    bus.rsp_ready = 1'b0;

    // Reset held 3 cycles with both requests pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_ce0", 64'(bus.sram_CE0), 64'd0);
      chk("rst_ce1", 64'(bus.sram_CE1), 64'd0);
      chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
      chk("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);

    // Different banks issue together
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00010; bus.wr_data = 64'h1111; bus.wr_mask = '1;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h02010;
    #1;
    chk("diff_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("diff_rd_ready", 64'(bus.rd_ready), 64'd1);
    chk("diff_ce0", 64'(bus.sram_CE0), 64'd1);
    chk("diff_ce1", 64'(bus.sram_CE1), 64'd1);
    chk("diff_a0", 64'(bus.sram_A0), 64'h00010);
    chk("diff_a1", 64'(bus.sram_A1), 64'h02010);
    chk("diff_cnt", 64'(bus.conflict_cnt), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    #1;
    chk("idle_a0_zero", 64'(bus.sram_A0), 64'd0);
    chk("lat_plus1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); #1;
    chk("lat_plus2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("lat_plus2_rsp_data", bus.rsp_data, 64'h0);

    // Same-bank conflict held 4 cycles alternates W,R,W,R
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = 18'h04000; bus.wr_data = 64'hC0;
      bus.rd_valid = 1'b1; bus.rd_addr = 18'h05FFF;
      #1;
      chk($sformatf("rr_wr_%0d", i), 64'(bus.wr_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("rr_rd_%0d", i), 64'(bus.rd_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    #1;
    chk("rr_cnt", 64'(bus.conflict_cnt), 64'd4);
    wait_rsp("rr_rsp", 64'h0);

    // Same address, write has priority: read sees new data
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00100; bus.wr_data = 64'h1234; bus.wr_mask = '1;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h00100;
    #1;
    chk("raw1_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("raw1_rd_ready", 64'(bus.rd_ready), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk("raw1_rd_late", 64'(bus.rd_ready), 64'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    wait_rsp("raw1_new_data", 64'h1234);

    // Same address, read has priority: read sees old data
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00100; bus.wr_data = 64'h5678;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h00100;
    #1;
    chk("raw2_rd_ready", 64'(bus.rd_ready), 64'd1);
    chk("raw2_wr_ready", 64'(bus.wr_ready), 64'd0);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    chk("raw2_wr_late", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    wait_rsp("raw2_old_data", 64'h1234);
    chk("raw_cnt", 64'(bus.conflict_cnt), 64'd6);

    // Bit-masked write merges into the stored word
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00100;
    bus.wr_data = 64'hAAAA_AAAA_AAAA_AAAA; bus.wr_mask = 64'hFFFF_0000_0000_0000;
    #1;
    chk("mask_wem0", bus.sram_WEM0, 64'hFFFF_0000_0000_0000);
    @(negedge clk);
    bus.wr_valid = 1'b0; bus.wr_mask = '1;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h00100;
    #1;
    chk("mask_rd_ready", 64'(bus.rd_ready), 64'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    wait_rsp("mask_data", 64'hAAAA_0000_0000_5678);

    // Preload 0x200..0x204 for the backpressure run
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = 18'(18'h00200 + i); bus.wr_data = 64'(64'hB0 + i);
    end
    @(negedge clk);
    bus.wr_valid  = 1'b0;
    bus.rsp_ready = 1'b0;
    acc = 0;

    // Backpressure: only RSP_DEPTH reads get in; writes to another bank keep flowing
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.rd_valid = 1'b1; bus.rd_addr = 18'(18'h00200 + acc);
      bus.wr_valid = (c == 4); bus.wr_addr = 18'h03000; bus.wr_data = 64'hDD;
      #1;
      if (c == 4) chk("bp_wr_free", 64'(bus.wr_ready), 64'd1);
      if (bus.rd_ready) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    chk("bp_stall", 64'(bus.rd_ready), 64'd0);

    acc_fast = 0;
    got.delete();
    for (int c = 0; c < 10 && got.size() < 5; c++) begin
      @(negedge clk);
      bus.wr_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.rd_valid  = (acc < 5);
      bus.rd_addr   = 18'(18'h00200 + acc);
      #1;
      if (bus.rsp_valid) got.push_back(bus.rsp_data);
      if (bus.rd_ready) begin
        acc++;
        if (c < 3) acc_fast++;
      end
    end
    bus.rd_valid = 1'b0;
    chk("bp_fast_accepts", 64'(acc_fast), 64'd3);
    chk("bp_rsp_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_data_%0d", i), (got.size() > i) ? got[i] : 64'hX, 64'(64'hB0 + i));
    end

    // Mid-operation reset drops an in-flight read and restores write priority
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00500; bus.wr_data = 64'hEE;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h00100;
    #1;
    chk("mid_pre_wr", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk("mid_rd_issue", 64'(bus.rd_ready), 64'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rsp_valid_0", 64'(bus.rsp_valid), 64'd0);
    chk("mid_cnt", 64'(bus.conflict_cnt), 64'd0);
    @(negedge clk); #1;
    chk("mid_rsp_valid_1", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 18'h00600; bus.wr_data = 64'hFF;
    bus.rd_valid = 1'b1; bus.rd_addr = 18'h00202;
    #1;
    chk("post_rst_prio_wr", 64'(bus.wr_ready), 64'd1);
    chk("post_rst_prio_rd", 64'(bus.rd_ready), 64'd0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk("post_rst_rd", 64'(bus.rd_ready), 64'd1);
    @(negedge clk);
    bus.rd_valid = 1'b0;
    #1;
    wait_rsp("post_rst_data", 64'hB2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
